// File: rtl/tlul_pkg.sv
// TL-UL channel bundles shared by hosts, devices and interconnect blocks.
// Pure type definitions, no logic and no latency.
// Flow control is carried in the a_valid/a_ready and d_valid/d_ready fields.
package tlul_pkg;

    // Host-to-device: A-channel request plus the host's D-channel ready.
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    // Device-to-host: D-channel response plus the device's A-channel ready.
    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arb.sv
// Round-robin arbiter sharing one in-order TL-UL device port among NumHosts hosts.
// Zero-latency combinational grant and D routing; outstanding count updates one cycle later.
// A stall holds the grant on the same host; no grant while MaxOutstanding requests are in flight.
module tlul_host_arb #(
    parameter int  NumHosts       = 3,
    parameter int  MaxOutstanding = 4,
    localparam int IdW            = $clog2(NumHosts),
    localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  tlul_pkg::tl_h2d_t  tl_h_i [NumHosts],
    output tlul_pkg::tl_d2h_t  tl_h_o [NumHosts],
    output tlul_pkg::tl_h2d_t  tl_d_o,
    input  tlul_pkg::tl_d2h_t  tl_d_i,
    output logic [CntW-1:0]    outstanding_o,
    output logic               unexpected_rsp_o
);

    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    // Outstanding host-ID FIFO: one entry per accepted request, popped per response.
    logic [IdW-1:0]  id_mem [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;

    // Arbitration state.
    logic            lock;
    logic [IdW-1:0]  locked_idx;
    logic [IdW-1:0]  rr_ptr;

    logic            gnt_vld;
    logic [IdW-1:0]  gnt_idx;
    logic [IdW-1:0]  head_idx;
    logic            full;
    logic            empty;
    logic            a_hs;
    logic            d_hs;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full is taken from the registered count so a same-cycle pop never frees a slot early.
    assign full          = (count == CntW'(MaxOutstanding));
    assign empty         = (count == '0);
    assign head_idx      = id_mem[rd_ptr];
    assign outstanding_o = count;
    assign a_hs          = tl_d_o.a_valid & tl_d_i.a_ready;
    assign d_hs          = ~empty & tl_d_i.d_valid & tl_d_o.d_ready;

    // Grant: stay on a stalled host, otherwise first requester after the last winner.
    always_comb begin
        logic [IdW-1:0] cand;
        int             j;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        j       = 0;
        if (!rst_i && !full) begin
            if (lock) begin
                gnt_vld = 1'b1;
                gnt_idx = locked_idx;
            end else begin
                for (int k = 1; k <= NumHosts; k++) begin
                    j = int'(rr_ptr) + k;
                    if (j >= NumHosts) begin
                        j = j - NumHosts;
                    end
                    cand = IdW'(j);
                    if (!gnt_vld && tl_h_i[cand].a_valid) begin
                        gnt_vld = 1'b1;
                        gnt_idx = cand;
                    end
                end
            end
        end
    end

    // A-channel mux to the device and D-channel routing back to the FIFO-head host.
    always_comb begin
        tl_d_o           = '0;
        unexpected_rsp_o = 1'b0;
        for (int i = 0; i < NumHosts; i++) begin
            tl_h_o[i] = '0;
        end
        if (!rst_i) begin
            if (gnt_vld) begin
                tl_d_o = tl_h_i[gnt_idx];
            end
            // With nothing outstanding a stray beat is accepted and dropped.
            tl_d_o.d_ready   = empty ? 1'b1 : tl_h_i[head_idx].d_ready;
            unexpected_rsp_o = empty & tl_d_i.d_valid;
            for (int i = 0; i < NumHosts; i++) begin
                if (!empty && head_idx == IdW'(i)) begin
                    tl_h_o[i]         = tl_d_i;
                    tl_h_o[i].a_ready = 1'b0;
                end
                if (gnt_vld && gnt_idx == IdW'(i)) begin
                    tl_h_o[i].a_ready = tl_d_i.a_ready;
                end
            end
        end
    end

    // FIFO pointers, count and arbitration state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            lock       <= 1'b0;
            locked_idx <= '0;
            rr_ptr     <= IdW'(NumHosts - 1);
        end else begin
            if (a_hs) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (d_hs) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({a_hs, d_hs})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (a_hs) begin
                lock   <= 1'b0;
                rr_ptr <= gnt_idx;
            end else if (tl_d_o.a_valid) begin
                lock       <= 1'b1;
                locked_idx <= gnt_idx;
            end
        end
    end

    // Host-ID storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (a_hs) begin
            id_mem[wr_ptr] <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_tlul_host_arb.sv
// Randomized bench for tlul_host_arb against a queue-based arbitration model.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// Device readiness varies by phase to exercise stalls, full FIFO and stray responses.
module tb_tlul_host_arb;
    import tlul_pkg::*;

    localparam int N    = 3;
    localparam int M    = 4;
    localparam int CntW = $clog2(M + 1);

    logic            clk = 1'b0;
    logic            rst;
    tl_h2d_t         h_req [N];
    tl_d2h_t         h_rsp [N];
    tl_h2d_t         d_req;
    tl_d2h_t         d_rsp;
    logic [CntW-1:0] outstanding;
    logic            unexpected;

    tlul_host_arb #(.NumHosts(N), .MaxOutstanding(M)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .tl_h_i           (h_req),
        .tl_h_o           (h_rsp),
        .tl_d_o           (d_req),
        .tl_d_i           (d_rsp),
        .outstanding_o    (outstanding),
        .unexpected_rsp_o (unexpected)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %0h want %0h", tag, cyc, act, exp);
        end
    endtask

    // Reference model: list of hosts whose requests are in flight, in issue order.
    int          q[$];
    int          last_gnt;
    int          stalled;
    bit          hv   [N];
    logic [31:0] haddr[N];
    logic [7:0]  hsrc [N];
    bit          hdr  [N];
    int          seq;
    int          pa;
    int          pd;
    int          g;
    int          h;
    bit          a_hs_m;
    bit          d_hs_m;
    bit          exp_dv;

    initial begin
        rst      = 1'b1;
        d_rsp    = '0;
        last_gnt = N - 1;
        stalled  = -1;
        seq      = 0;
        for (int i = 0; i < N; i++) begin
            h_req[i] = '0;
            hv[i]    = 1'b0;
            haddr[i] = '0;
            hsrc[i]  = '0;
            hdr[i]   = 1'b0;
        end

        for (cyc = 0; cyc < 1200; cyc++) begin
            @(negedge clk);
            if (cyc < 300) begin
                pa = 70; pd = 60;
            end else if (cyc < 600) begin
                pa = 80; pd = 10;
            end else if (cyc < 900) begin
                pa = 20; pd = 50;
            end else begin
                pa = 60; pd = 40;
            end
            rst = (cyc < 2) || (cyc >= 450 && cyc < 452);

            // Hosts hold a request until it is accepted, then may issue another.
            for (int i = 0; i < N; i++) begin
                if (!hv[i] && $urandom_range(0, 99) < 50) begin
                    hv[i]    = 1'b1;
                    haddr[i] = (32'(i) << 28) | 32'(seq);
                    hsrc[i]  = 8'($urandom);
                    seq++;
                end
                hdr[i]             = ($urandom_range(0, 99) < 80);
                h_req[i]           = '0;
                h_req[i].a_valid   = hv[i];
                h_req[i].a_opcode  = 3'd4;
                h_req[i].a_size    = 2'd2;
                h_req[i].a_mask    = 4'hf;
                h_req[i].a_address = haddr[i];
                h_req[i].a_source  = hsrc[i];
                h_req[i].d_ready   = hdr[i];
            end
            d_rsp          = '0;
            d_rsp.a_ready  = ($urandom_range(0, 99) < pa);
            d_rsp.d_valid  = ($urandom_range(0, 99) < pd);
            d_rsp.d_opcode = 3'd1;
            d_rsp.d_size   = 2'd2;
            d_rsp.d_source = 8'($urandom);
            d_rsp.d_data   = $urandom;
            #1;

            // Expected grant from the arbitration rules.
            g = -1;
            if (!rst && q.size() < M) begin
                if (stalled >= 0) begin
                    g = stalled;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        h = (last_gnt + k) % N;
                        if (g < 0 && hv[h]) g = h;
                    end
                end
            end

            check_eq("outstanding", 64'(outstanding), 64'(q.size()));
            check_eq("dev_a_valid", 64'(d_req.a_valid), 64'(g >= 0));
            if (g >= 0) begin
                check_eq("dev_a_address", 64'(d_req.a_address), 64'(haddr[g]));
                check_eq("dev_a_source", 64'(d_req.a_source), 64'(hsrc[g]));
            end
            if (rst)
                check_eq("dev_d_ready", 64'(d_req.d_ready), 64'(0));
            else if (q.size() == 0)
                check_eq("dev_d_ready", 64'(d_req.d_ready), 64'(1));
            else
                check_eq("dev_d_ready", 64'(d_req.d_ready), 64'(hdr[q[0]]));
            check_eq("unexpected", 64'(unexpected), 64'(!rst && q.size() == 0 && d_rsp.d_valid));
            for (int i = 0; i < N; i++) begin
                exp_dv = !rst && q.size() > 0 && q[0] == i && d_rsp.d_valid;
                check_eq($sformatf("h%0d_a_ready", i), 64'(h_rsp[i].a_ready), 64'(g == i && d_rsp.a_ready));
                check_eq($sformatf("h%0d_d_valid", i), 64'(h_rsp[i].d_valid), 64'(exp_dv));
                if (exp_dv) begin
                    check_eq($sformatf("h%0d_d_data", i), 64'(h_rsp[i].d_data), 64'(d_rsp.d_data));
                end
            end

            // Advance the model by what the rules say happens at this edge.
            if (rst) begin
                q.delete();
                last_gnt = N - 1;
                stalled  = -1;
            end else begin
                d_hs_m = q.size() > 0 && d_rsp.d_valid && hdr[q[0]];
                a_hs_m = g >= 0 && d_rsp.a_ready;
                if (d_hs_m) void'(q.pop_front());
                if (a_hs_m) begin
                    q.push_back(g);
                    last_gnt = g;
                    stalled  = -1;
                    hv[g]    = 1'b0;
                end else if (g >= 0) begin
                    stalled = g;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
